// File: rtl/adder16_rr_sched.sv
// Round-robin front end for a shared two-stage registered adder.
// Stage 1 launches the granted operands, stage 2 captures sum/carry and drives the response port.
module adder16_rr_sched #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 16,
  parameter int ID_W    = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [ID_W-1:0]          rsp_id,
  output logic [WIDTH-1:0]         rsp_sum,
  output logic                     rsp_carry,
  output logic                     busy
);

  localparam int PTR_W = $clog2(NUM_REQ);

  logic [PTR_W-1:0]   ptr_reg, ptr_next;
  logic               s1_valid_reg;
  logic [WIDTH-1:0]   s1_a_reg, s1_b_reg;
  logic [ID_W-1:0]    s1_id_reg;
  logic               s2_valid_reg;
  logic [WIDTH-1:0]   s2_sum_reg;
  logic               s2_carry_reg;
  logic [ID_W-1:0]    s2_id_reg;

  logic               adv1, adv2, fire;
  logic [NUM_REQ-1:0] hi_mask, req_hi, req_pick, grant;
  logic [PTR_W-1:0]   grant_idx;
  logic [WIDTH-1:0]   sel_a, sel_b;
  logic [WIDTH:0]     sum_full;

  assign adv2 = !s2_valid_reg || rsp_ready;
  assign adv1 = !s1_valid_reg || adv2;

  // Requesters at or above the pointer win first; otherwise fall back to the full set (wrap).
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_mask
      assign hi_mask[gi] = (PTR_W'(gi) >= ptr_reg);
    end
  endgenerate

  assign req_hi   = req_valid & hi_mask;
  assign req_pick = (|req_hi) ? req_hi : req_valid;
  assign grant    = req_pick & ((~req_pick) + NUM_REQ'(1));
  assign fire     = (|req_valid) && adv1 && rst_n;
  assign req_ready = grant & {NUM_REQ{fire}};

  always_comb begin
    grant_idx = '0;
    sel_a     = '0;
    sel_b     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        grant_idx = PTR_W'(i);
        sel_a     = req_a[i*WIDTH +: WIDTH];
        sel_b     = req_b[i*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    ptr_next = ptr_reg;
    if (fire) begin
      ptr_next = (grant_idx == PTR_W'(NUM_REQ-1)) ? '0 : grant_idx + PTR_W'(1);
    end
  end

  assign sum_full = {1'b0, s1_a_reg} + {1'b0, s1_b_reg};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_reg      <= '0;
      s1_valid_reg <= 1'b0;
      s1_a_reg     <= '0;
      s1_b_reg     <= '0;
      s1_id_reg    <= '0;
      s2_valid_reg <= 1'b0;
      s2_sum_reg   <= '0;
      s2_carry_reg <= 1'b0;
      s2_id_reg    <= '0;
    end else begin
      ptr_reg <= ptr_next;
      if (adv2) begin
        s2_valid_reg <= s1_valid_reg;
        s2_sum_reg   <= sum_full[WIDTH-1:0];
        s2_carry_reg <= sum_full[WIDTH];
        s2_id_reg    <= s1_id_reg;
      end
      if (adv1) begin
        s1_valid_reg <= fire;
        if (fire) begin
          s1_a_reg  <= sel_a;
          s1_b_reg  <= sel_b;
          s1_id_reg <= ID_W'(grant_idx);
        end
      end
    end
  end

  assign rsp_valid = s2_valid_reg;
  assign rsp_id    = s2_id_reg;
  assign rsp_sum   = s2_sum_reg;
  assign rsp_carry = s2_carry_reg;
  assign busy      = s1_valid_reg | s2_valid_reg;

endmodule

// File: tb/tb_adder16_rr_sched.sv
// Bench for adder16_rr_sched: directed scenarios plus randomized traffic
// checked against a capacity-2 in-order queue model with a modular RR pointer.
module tb_adder16_rr_sched;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [63:0] req_a;
  logic [63:0] req_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_id;
  logic [15:0] rsp_sum;
  logic        rsp_carry;
  logic        busy;

  int checks = 0;
  int passes = 0;

  adder16_rr_sched #(.NUM_REQ(4), .WIDTH(16), .ID_W(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_sum(rsp_sum), .rsp_carry(rsp_carry),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: ops in flight, oldest first; at most two (launch + capture).
  typedef struct {
    int unsigned id;
    int unsigned a;
    int unsigned b;
    bit          at_capture;
  } op_t;

  op_t         pipe[$];
  int unsigned m_ptr;
  int          m_grant;
  logic [3:0]  exp_ready;
  logic        exp_valid;
  logic        exp_busy;
  logic [1:0]  exp_id;
  logic [15:0] exp_sum;
  logic        exp_carry;

  task automatic predict();
    int unsigned t;
    int unsigned cand;
    bit room;
    exp_busy  = (pipe.size() != 0);
    exp_valid = exp_busy && pipe[0].at_capture;
    exp_id = '0; exp_sum = '0; exp_carry = 1'b0;
    if (exp_valid) begin
      t = pipe[0].a + pipe[0].b;
      exp_sum   = 16'(t % 65536);
      exp_carry = (t >= 65536);
      exp_id    = 2'(pipe[0].id);
    end
    room = (pipe.size() < 2) || rsp_ready;
    m_grant = -1;
    if (room) begin
      for (int k = 0; k < 4; k++) begin
        cand = (m_ptr + k) % 4;
        if (m_grant < 0 && req_valid[cand]) m_grant = int'(cand);
      end
    end
    exp_ready = (m_grant < 0) ? 4'b0000 : 4'(1 << m_grant);
  endtask

  task automatic commit();
    op_t op;
    if (exp_valid && rsp_ready) void'(pipe.pop_front());
    if (pipe.size() == 1 && !pipe[0].at_capture) begin
      op = pipe[0];
      op.at_capture = 1'b1;
      pipe[0] = op;
    end
    if (m_grant >= 0) begin
      op.id = m_grant;
      op.a = req_a[m_grant*16 +: 16];
      op.b = req_b[m_grant*16 +: 16];
      op.at_capture = 1'b0;
      pipe.push_back(op);
      m_ptr = (m_grant + 1) % 4;
    end
  endtask

  task automatic randomize_operands();
    for (int i = 0; i < 4; i++) begin
      req_a[i*16 +: 16] = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
      req_b[i*16 +: 16] = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
    end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; req_valid = '0; rsp_ready = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    pipe.delete();
    m_ptr = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 4'hF; rsp_ready = 1'b1; req_a = '0; req_b = '0;
    #3;
    checks++; if (req_ready !== 4'b0000) $display("FAIL reset_ready: got %b want 0000", req_ready); else passes++;
    checks++; if (rsp_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", rsp_valid); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passes++;
    checks++; if (rsp_sum !== 16'h0) $display("FAIL reset_sum: got %h want 0000", rsp_sum); else passes++;
    checks++; if (rsp_carry !== 1'b0) $display("FAIL reset_carry: got %b want 0", rsp_carry); else passes++;
    checks++; if (rsp_id !== 2'd0) $display("FAIL reset_id: got %0d want 0", rsp_id); else passes++;
    @(posedge clk); #1;
    checks++; if (req_ready !== 4'b0000) $display("FAIL reset_ready_edge: got %b want 0000", req_ready); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy_edge: got %b want 0", busy); else passes++;
    $display("test_reset done");
  endtask

  task automatic test_single();
    apply_reset();
    req_valid = 4'b0100; req_a[32 +: 16] = 16'h1234; req_b[32 +: 16] = 16'h0001; rsp_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b0100) $display("FAIL single_grant: got %b want 0100", req_ready); else passes++;
    @(posedge clk); #1;
    req_valid = '0;
    #1;
    checks++; if (rsp_valid !== 1'b0) $display("FAIL single_early: got %b want 0", rsp_valid); else passes++;
    checks++; if (busy !== 1'b1) $display("FAIL single_busy: got %b want 1", busy); else passes++;
    @(posedge clk); #1;
    checks++; if (rsp_valid !== 1'b1) $display("FAIL single_valid: got %b want 1", rsp_valid); else passes++;
    checks++; if (rsp_sum !== 16'h1235) $display("FAIL single_sum: got %h want 1235", rsp_sum); else passes++;
    checks++; if (rsp_carry !== 1'b0) $display("FAIL single_carry: got %b want 0", rsp_carry); else passes++;
    checks++; if (rsp_id !== 2'd2) $display("FAIL single_id: got %0d want 2", rsp_id); else passes++;
    @(posedge clk); #1;
    checks++; if (rsp_valid !== 1'b0) $display("FAIL single_retire: got %b want 0", rsp_valid); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL single_idle: got %b want 0", busy); else passes++;
    $display("test_single: id=2 sum=%h carry=%b", 16'h1235, 1'b0);
  endtask

  task automatic test_overflow();
    req_valid = 4'b0010; req_a[16 +: 16] = 16'hFFFF; req_b[16 +: 16] = 16'h0002; rsp_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b0010) $display("FAIL ovf_grant: got %b want 0010", req_ready); else passes++;
    @(posedge clk); #1;
    req_valid = '0;
    @(posedge clk); #1;
    checks++; if (rsp_valid !== 1'b1) $display("FAIL ovf_valid: got %b want 1", rsp_valid); else passes++;
    checks++; if (rsp_sum !== 16'h0001) $display("FAIL ovf_sum: got %h want 0001", rsp_sum); else passes++;
    checks++; if (rsp_carry !== 1'b1) $display("FAIL ovf_carry: got %b want 1", rsp_carry); else passes++;
    checks++; if (rsp_id !== 2'd1) $display("FAIL ovf_id: got %0d want 1", rsp_id); else passes++;
    @(posedge clk); #1;
    $display("test_overflow: FFFF+0002 -> sum=0001 carry=1");
  endtask

  task automatic test_round_robin();
    int unsigned sums[$];
    int unsigned obs_id[$];
    int unsigned obs_sum[$];
    logic [3:0] want;
    apply_reset();
    rsp_ready = 1'b1;
    for (int c = 0; c < 11; c++) begin
      req_valid = (c < 8) ? 4'hF : 4'h0;
      randomize_operands();
      #1;
      if (c < 8) begin
        want = 4'(1 << (c % 4));
        checks++; if (req_ready !== want) $display("FAIL rr_grant c=%0d: got %b want %b", c, req_ready, want); else passes++;
        sums.push_back((req_a[(c%4)*16 +: 16] + req_b[(c%4)*16 +: 16]) % 65536);
      end
      if (rsp_valid === 1'b1) begin
        obs_id.push_back(rsp_id);
        obs_sum.push_back(rsp_sum);
      end
      @(posedge clk); #1;
    end
    checks++; if (obs_id.size() != 8) $display("FAIL rr_count: got %0d want 8", obs_id.size()); else passes++;
    for (int i = 0; i < obs_id.size() && i < 8; i++) begin
      checks++; if (obs_id[i] != (i % 4)) $display("FAIL rr_id[%0d]: got %0d want %0d", i, obs_id[i], i % 4); else passes++;
      checks++; if (obs_sum[i] != sums[i]) $display("FAIL rr_sum[%0d]: got %h want %h", i, obs_sum[i], sums[i]); else passes++;
    end
    $display("test_round_robin: %0d responses", obs_id.size());
  endtask

  task automatic test_wrap();
    rsp_ready = 1'b1;
    req_valid = 4'b0100;
    #1;
    checks++; if (req_ready !== 4'b0100) $display("FAIL wrap_setup: got %b want 0100", req_ready); else passes++;
    @(posedge clk); #1;
    req_valid = 4'b1001;
    #1;
    checks++; if (req_ready !== 4'b1000) $display("FAIL wrap_first: got %b want 1000", req_ready); else passes++;
    @(posedge clk); #1;
    #1;
    checks++; if (req_ready !== 4'b0001) $display("FAIL wrap_second: got %b want 0001", req_ready); else passes++;
    @(posedge clk); #1;
    req_valid = '0;
    repeat (3) @(posedge clk);
    #1;
    $display("test_wrap: grants 3 then 0");
  endtask

  task automatic test_backpressure();
    int accepted;
    int responses;
    int grants;
    apply_reset();
    accepted = 0; responses = 0; grants = 0;
    for (int c = 0; c < 16; c++) begin
      req_valid = (c < 11) ? 4'hF : 4'h0;
      rsp_ready = (c >= 5);
      randomize_operands();
      #1;
      predict();
      if (c < 5 && req_ready !== 4'b0000) accepted++;
      if (rsp_valid === 1'b1 && rsp_ready) responses++;
      if (m_grant >= 0) grants++;
      checks++; if (req_ready !== exp_ready) $display("FAIL bp_ready c=%0d: got %b want %b", c, req_ready, exp_ready); else passes++;
      checks++; if (rsp_valid !== exp_valid) $display("FAIL bp_valid c=%0d: got %b want %b", c, rsp_valid, exp_valid); else passes++;
      checks++; if (busy !== exp_busy) $display("FAIL bp_busy c=%0d: got %b want %b", c, busy, exp_busy); else passes++;
      if (exp_valid) begin
        checks++; if (rsp_id !== exp_id) $display("FAIL bp_id c=%0d: got %0d want %0d", c, rsp_id, exp_id); else passes++;
        checks++; if (rsp_sum !== exp_sum) $display("FAIL bp_sum c=%0d: got %h want %h", c, rsp_sum, exp_sum); else passes++;
        checks++; if (rsp_carry !== exp_carry) $display("FAIL bp_carry c=%0d: got %b want %b", c, rsp_carry, exp_carry); else passes++;
      end
      commit();
      @(posedge clk); #1;
    end
    checks++; if (accepted != 2) $display("FAIL bp_stall_accepts: got %0d want 2", accepted); else passes++;
    checks++; if (responses != grants) $display("FAIL bp_no_loss: got %0d responses want %0d", responses, grants); else passes++;
    $display("test_backpressure: accepted_in_stall=%0d grants=%0d responses=%0d", accepted, grants, responses);
  endtask

  task automatic test_reset_mid();
    apply_reset();
    rsp_ready = 1'b0; req_valid = 4'hF;
    randomize_operands();
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++; if (busy !== 1'b1) $display("FAIL mid_full_busy: got %b want 1", busy); else passes++;
    checks++; if (rsp_valid !== 1'b1) $display("FAIL mid_full_valid: got %b want 1", rsp_valid); else passes++;
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (rsp_valid !== 1'b0) $display("FAIL mid_rst_valid: got %b want 0", rsp_valid); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL mid_rst_busy: got %b want 0", busy); else passes++;
    checks++; if (req_ready !== 4'b0000) $display("FAIL mid_rst_ready: got %b want 0000", req_ready); else passes++;
    @(posedge clk); #1;
    rst_n = 1'b1; rsp_ready = 1'b1; req_valid = 4'hF;
    req_a[0 +: 16] = 16'h00A0; req_b[0 +: 16] = 16'h000B;
    #1;
    checks++; if (req_ready !== 4'b0001) $display("FAIL mid_after_grant: got %b want 0001", req_ready); else passes++;
    @(posedge clk); #1;
    req_valid = '0;
    #1;
    checks++; if (rsp_valid !== 1'b0) $display("FAIL mid_no_stale: got %b want 0", rsp_valid); else passes++;
    @(posedge clk); #1;
    checks++; if (rsp_valid !== 1'b1) $display("FAIL mid_after_valid: got %b want 1", rsp_valid); else passes++;
    checks++; if (rsp_id !== 2'd0) $display("FAIL mid_after_id: got %0d want 0", rsp_id); else passes++;
    checks++; if (rsp_sum !== 16'h00AB) $display("FAIL mid_after_sum: got %h want 00ab", rsp_sum); else passes++;
    @(posedge clk); #1;
    $display("test_reset_mid done");
  endtask

  task automatic test_random();
    int n_rsp;
    apply_reset();
    n_rsp = 0;
    for (int c = 0; c < 400; c++) begin
      req_valid = (c < 390) ? 4'($urandom) : 4'h0;
      rsp_ready = (c >= 390) || ($urandom_range(0, 3) != 0);
      randomize_operands();
      #1;
      predict();
      checks++; if (req_ready !== exp_ready) $display("FAIL rand_ready c=%0d: got %b want %b", c, req_ready, exp_ready); else passes++;
      checks++; if (rsp_valid !== exp_valid) $display("FAIL rand_valid c=%0d: got %b want %b", c, rsp_valid, exp_valid); else passes++;
      checks++; if (busy !== exp_busy) $display("FAIL rand_busy c=%0d: got %b want %b", c, busy, exp_busy); else passes++;
      if (exp_valid) begin
        checks++; if (rsp_id !== exp_id) $display("FAIL rand_id c=%0d: got %0d want %0d", c, rsp_id, exp_id); else passes++;
        checks++; if (rsp_sum !== exp_sum) $display("FAIL rand_sum c=%0d: got %h want %h", c, rsp_sum, exp_sum); else passes++;
        checks++; if (rsp_carry !== exp_carry) $display("FAIL rand_carry c=%0d: got %b want %b", c, rsp_carry, exp_carry); else passes++;
        if (rsp_ready) n_rsp++;
      end
      commit();
      @(posedge clk); #1;
    end
    checks++; if (pipe.size() != 0 || busy !== 1'b0) $display("FAIL rand_drain: got busy=%b model_ops=%0d want 0/0", busy, pipe.size()); else passes++;
    $display("test_random: %0d responses retired", n_rsp);
  endtask

  initial begin
    test_reset();
    test_single();
    test_overflow();
    test_round_robin();
    test_wrap();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
